// File: rtl/mem_pkg.sv
// Shared types and widths for the word-addressed memory responder.
// Holds the responder FSM state encoding and the request address check.
package mem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // A byte address is rejected when misaligned or past the last word.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a, input int unsigned depth);
    return (a[1:0] != 2'b00) || ({2'b00, a[ADDR_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a core (master) and the memory responder (slave).
interface mem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_array.sv
// Single-port word storage: synchronous byte-masked write, registered read.
module mem_array
  import mem_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (wstrb_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request, waits WAIT cycles, commits to the
// array on the edge entering RESP and returns a one-cycle response.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int WAIT_M1 = (WAIT > 0) ? WAIT - 1 : 0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              commit;
  logic              cur_we;
  logic              cur_err;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [STRB_W-1:0] cur_wstrb;
  logic [DATA_W-1:0] arr_rdata;

  // With WAIT = 0 the commit happens on the accepting edge, so it must use the live bus fields.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_wstrb = wstrb_q;
    if (state_q == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_wstrb = bus.req_wstrb;
    end
  end

  assign cur_err = addr_err(cur_addr, DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d = bus.req_we;
          if (WAIT == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(WAIT_M1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) err_d = cur_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.req_valid) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      wstrb_q <= bus.req_wstrb;
    end
  end

  // The array has no reset, so a commit must never slip through while reset is held.
  mem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .en_i    (commit && reset && !cur_err),
    .we_i    (cur_we),
    .idx_i   (cur_addr[IDX_W+1:2]),
    .wdata_i (cur_wdata),
    .wstrb_i (cur_wstrb),
    .rdata_o (arr_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && err_q;
  assign bus.rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT=2 and WAIT=0, DEPTH=16) checked
// every cycle against a transaction-level memory model, plus directed cases.
module tb_mem_responder;

  localparam int DEP = 16;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if ba ();
  mem_responder_if bb ();

  mem_responder #(.DEPTH(DEP), .WAIT(2)) dut_a (.clk(clk), .reset(rst_a_n), .bus(ba));
  mem_responder #(.DEPTH(DEP), .WAIT(0)) dut_b (.clk(clk), .reset(rst_b_n), .bus(bb));

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;

  // Reference model state, indexed by instance (0: WAIT=2, 1: WAIT=0).
  logic [31:0] refm [2][DEP];
  logic [3:0]  kb   [2][DEP] = '{default: '0};
  bit          pend [2] = '{0, 0};
  int unsigned rsp_at [2];
  int unsigned free_at [2] = '{0, 0};
  logic        pwe [2];
  logic [31:0] paddr [2];
  logic [31:0] pwd [2];
  logic [3:0]  pst [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_step(input int d, input logic rn, input logic v, input logic we,
                            input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                            input logic rdy, input logic rv, input logic [31:0] rd, input logic er);
    int unsigned w;
    int unsigned wi;
    logic [31:0] msk;
    logic exp_rv;
    w = (d == 0) ? 2 : 0;
    if (!rn) begin
      pend[d] = 0;
      free_at[d] = 0;
      chk($sformatf("rst_ready%0d", d), {31'd0, rdy}, 32'd1);
      chk($sformatf("rst_valid%0d", d), {31'd0, rv}, 32'd0);
      chk($sformatf("rst_rdata%0d", d), rd, 32'd0);
      chk($sformatf("rst_err%0d", d), {31'd0, er}, 32'd0);
      return;
    end
    chk($sformatf("ready%0d", d), {31'd0, rdy}, {31'd0, cyc >= free_at[d]});
    exp_rv = pend[d] && (cyc == rsp_at[d]);
    chk($sformatf("rsp_valid%0d", d), {31'd0, rv}, {31'd0, exp_rv});
    if (exp_rv) begin
      pend[d] = 0;
      if (paddr[d][1:0] != 0 || (paddr[d] >> 2) >= DEP) begin
        chk($sformatf("err%0d", d), {31'd0, er}, 32'd1);
        chk($sformatf("err_rdata%0d", d), rd, 32'd0);
      end else begin
        wi = paddr[d] >> 2;
        chk($sformatf("ok_err%0d", d), {31'd0, er}, 32'd0);
        if (pwe[d]) begin
          chk($sformatf("wr_rdata%0d", d), rd, 32'd0);
          for (int b = 0; b < 4; b++) begin
            if (pst[d][b]) begin
              refm[d][wi][8*b +: 8] = pwd[d][8*b +: 8];
              kb[d][wi][b] = 1'b1;
            end
          end
        end else begin
          for (int b = 0; b < 4; b++) msk[8*b +: 8] = {8{kb[d][wi][b]}};
          chk($sformatf("rd_rdata%0d", d), rd & msk, refm[d][wi] & msk);
        end
      end
    end else begin
      chk($sformatf("idle_rdata%0d", d), rd, 32'd0);
      chk($sformatf("idle_err%0d", d), {31'd0, er}, 32'd0);
    end
    if (cyc >= free_at[d] && v) begin
      pend[d]    = 1;
      rsp_at[d]  = cyc + 1 + w;
      free_at[d] = cyc + 2 + w;
      pwe[d] = we; paddr[d] = a; pwd[d] = wd; pst[d] = st;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    model_step(0, rst_a_n, ba.req_valid, ba.req_we, ba.req_addr, ba.req_wdata, ba.req_wstrb,
               ba.req_ready, ba.rsp_valid, ba.rsp_rdata, ba.rsp_err);
    model_step(1, rst_b_n, bb.req_valid, bb.req_we, bb.req_addr, bb.req_wdata, bb.req_wstrb,
               bb.req_ready, bb.rsp_valid, bb.rsp_rdata, bb.rsp_err);
  end

  task automatic drive(input int d, input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    if (d == 0) begin
      ba.req_valid = v; ba.req_we = we; ba.req_addr = a; ba.req_wdata = wd; ba.req_wstrb = st;
    end else begin
      bb.req_valid = v; bb.req_we = we; bb.req_addr = a; bb.req_wdata = wd; bb.req_wstrb = st;
    end
  endtask

  function automatic logic get_rdy(input int d);
    return (d == 0) ? ba.req_ready : bb.req_ready;
  endfunction

  function automatic logic get_rv(input int d);
    return (d == 0) ? ba.rsp_valid : bb.rsp_valid;
  endfunction

  // One complete transaction; request fields are scrambled right after acceptance.
  task automatic do_req(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er,
                        output int lat);
    bit acc = 0;
    bit got = 0;
    int unsigned n = 0;
    rd = 32'd0; er = 1'b0; lat = -1;
    @(posedge clk); #1;
    drive(d, 1'b1, we, a, wd, st);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (get_rdy(d)) begin acc = 1; n = cyc + 1; end
    end
    chk("accept", {31'd0, acc}, 32'd1);
    @(posedge clk); #1;
    drive(d, 1'b0, ~we, 32'hFFFF_FFF3, ~wd, ~st);
    for (int i = 0; i < 50 && !got && acc; i++) begin
      if (i > 0 || d == 0) @(negedge clk);
      else @(negedge clk);
      if (get_rv(d)) begin
        got = 1;
        rd  = (d == 0) ? ba.rsp_rdata : bb.rsp_rdata;
        er  = (d == 0) ? ba.rsp_err : bb.rsp_err;
        lat = int'(cyc - n);
      end
    end
    chk("response", {31'd0, got}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          nrsp;
  int          k;
  int          n_it;
  bit          acc_b;

  initial begin
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    chk("reset_ready", {31'd0, ba.req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, ba.rsp_valid}, 32'd0);
    chk("reset_rdata", ba.rsp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1; rst_a_n = 1'b1; rst_b_n = 1'b1;

    // Basic write then read back, WAIT=2.
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr10_err", {31'd0, er}, 32'd0);
    chk("wr10_rdata", rd, 32'd0);
    chk("wr10_latency", lat, 32'd2);
    do_req(0, 1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat);
    chk("rd10_rdata", rd, 32'hDEADBEEF);
    chk("rd10_latency", lat, 32'd2);

    // Byte strobes.
    do_req(0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    do_req(0, 1'b1, 32'h14, 32'h00000000, 4'b0101, rd, er, lat);
    do_req(0, 1'b1, 32'h14, 32'h12345678, 4'b0000, rd, er, lat);
    do_req(0, 1'b0, 32'h14, 32'd0, 4'h0, rd, er, lat);
    chk("rd14_strobed", rd, 32'hFF00FF00);

    // Error responses leave the array untouched.
    do_req(0, 1'b1, 32'h0, 32'hA5A50001, 4'hF, rd, er, lat);
    do_req(0, 1'b0, 32'h2, 32'd0, 4'h0, rd, er, lat);
    chk("misalign_err", {31'd0, er}, 32'd1);
    chk("misalign_rdata", rd, 32'd0);
    do_req(0, 1'b0, 32'(4 * DEP), 32'd0, 4'h0, rd, er, lat);
    chk("range_err", {31'd0, er}, 32'd1);
    chk("range_latency", lat, 32'd2);
    do_req(0, 1'b1, 32'h1, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk("wr_misalign_err", {31'd0, er}, 32'd1);
    do_req(0, 1'b0, 32'h0, 32'd0, 4'h0, rd, er, lat);
    chk("rd0_unchanged", rd, 32'hA5A50001);
    chk("rd0_err", {31'd0, er}, 32'd0);

    // Reset while BUSY abandons the write.
    do_req(0, 1'b1, 32'h20, 32'h11112222, 4'hF, rd, er, lat);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    acc_b = 0;
    for (int i = 0; i < 20 && !acc_b; i++) begin
      @(negedge clk);
      if (ba.req_ready) acc_b = 1;
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #2; rst_a_n = 1'b0;
    #1;
    chk("rst_async_ready", {31'd0, ba.req_ready}, 32'd1);
    nrsp = 0;
    repeat (3) begin @(negedge clk); if (ba.rsp_valid) nrsp++; end
    @(posedge clk); #1; rst_a_n = 1'b1;
    repeat (4) begin @(negedge clk); if (ba.rsp_valid) nrsp++; end
    chk("abandon_rsp", nrsp, 32'd0);
    do_req(0, 1'b0, 32'h20, 32'd0, 4'h0, rd, er, lat);
    chk("rd20_prior", rd, 32'h11112222);

    // WAIT=0 with req_valid held high: accepts every other edge, nothing lost.
    @(posedge clk); #1;
    k = 0; nrsp = 0; n_it = 0;
    drive(1, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF);
    while (k < 16 && n_it < 80) begin
      @(negedge clk);
      n_it++;
      if (bb.rsp_valid) nrsp++;
      acc_b = bb.req_ready;
      @(posedge clk); #1;
      if (acc_b) begin
        k++;
        if (k < 8)       drive(1, 1'b1, 1'b1, 32'(k * 4), 32'(k) * 32'h1111, 4'hF);
        else if (k < 16) drive(1, 1'b1, 1'b0, 32'((k - 8) * 4), 32'd0, 4'h0);
        else             drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      end
    end
    repeat (3) begin @(negedge clk); if (bb.rsp_valid) nrsp++; end
    chk("b2b_accepts", k, 32'd16);
    chk("b2b_edges", n_it, 32'd31);
    chk("b2b_responses", nrsp, 32'd16);
    do_req(1, 1'b0, 32'h14, 32'd0, 4'h0, rd, er, lat);
    chk("b_rd5", rd, 32'h5555);
    chk("b_latency", lat, 32'd0);

    // Random traffic on both instances; the model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        logic [31:0] a;
        a = 32'($urandom_range(0, DEP + 3)) * 4;
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) a = a | 32'h8000_0000;
        drive(d, ($urandom_range(0, 2) != 0), 1'($urandom), a, $urandom, 4'($urandom));
      end
      if (i == 300) begin #2; rst_b_n = 1'b0; end
      if (i == 302) rst_b_n = 1'b1;
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words in the array (power of two, 4..4096).
REQ-002 SHALL have parameter WAIT, default 2, number of wait-state cycles per access (0..15).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  core presents a request.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  write data.
REQ-009 SHALL have port req_wstrb  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-010 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err  output  1  access rejected, qualified by rsp_valid.

Function
REQ-014 SHALL implement states IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on a rising edge where state = IDLE, req_valid = 1 and req_ready = 1; at that edge it SHALL register we, addr, wdata and wstrb. The core need not hold them afterwards.
REQ-016 From IDLE on acceptance, SHALL go to BUSY if WAIT > 0 and load the wait counter with WAIT-1. If WAIT = 0, SHALL go directly to RESP.
REQ-017 In BUSY, SHALL decrement the counter each edge and leave for RESP on the edge where the counter equals 0.
REQ-018 The commit edge SHALL be the edge that enters RESP; the array write and read capture SHALL occur only there.
REQ-019 For request accepted at edge N, rsp_valid SHALL be 1 for exactly the cycle after edge N+WAIT.
REQ-020 RESP SHALL unconditionally return to IDLE on the next edge; req_ready SHALL reassert in the cycle after edge N+WAIT+1.
REQ-021 Maximum throughput SHALL be one request per WAIT+2 cycles.
REQ-022 Error condition: addr[1:0] != 0 or word index addr[31:2] >= DEPTH.
REQ-023 On error, SHALL leave the array unmodified and return rsp_err = 1 and rsp_rdata = 0, with normal latency.
REQ-024 Valid write: at the commit edge, SHALL update only the byte lanes with wstrb = 1; wstrb = 0000 SHALL be a legal no-op write. rsp_rdata = 0 and rsp_err = 0.
REQ-025 Valid read: rsp_rdata SHALL equal the word contents as of the commit edge, including any write committed by an earlier request (no stale data).
REQ-026 SHALL ignore req_valid in BUSY and RESP (no queueing, no effect on state).
REQ-027 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid = 0.

Reset
REQ-028 While reset = 0, SHALL force state to IDLE, counter to 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0, independent of clk.
REQ-029 Reset asserted before the commit edge SHALL abandon the in-flight request: no array write, no response after release.
REQ-030 Array contents SHALL NOT be cleared by reset.
REQ-031 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-032 Shared package mem_pkg SHALL hold the state enum (IDLE, BUSY, RESP), DATA_W = 32, ADDR_W = 32 and STRB_W = 4.
REQ-033 The storage SHALL be a sub-module mem_array: single port, synchronous byte-masked write, registered read, DEPTH words.
REQ-034 mem_responder SHALL contain only the FSM, counter, request registers and error check.

Verification
REQ-035 Write/read, WAIT=2: write 0x0000_0010 <- 0xDEADBEEF, strb 1111, accepted at edge N -> rsp_valid in cycle after N+2, err 0; then read 0x10 -> rdata 0xDEADBEEF.
REQ-036 Byte strobes: write 0x14 <- 0xFFFFFFFF, then write 0x14 <- 0x00000000 with strb 0101 -> read 0x14 returns 0xFF00FF00.
REQ-037 Errors: read 0x0000_0002 and read 4*DEPTH -> rsp_err 1, rdata 0; a following read of word 0 returns its unchanged value.
REQ-038 Busy ignore, WAIT=0: hold req_valid high continuously -> accepts every 2nd edge, rsp_valid pulses alternate cycles, no request lost or duplicated.
REQ-039 Reset mid-access: write 0x20 <- 0x12345678, reset low during BUSY -> no rsp_valid; a read of 0x20 after release returns the prior contents.
REQ-040 Random stimulus: compare against a reference memory model -> every rsp_valid falls WAIT+1 cycles after acceptance, and req_ready never asserts outside IDLE.
